// File: rtl/uart_rx_byte_pkg.sv
// rtl/uart_rx_byte_pkg.sv - shared FSM encodings and key codes for the UART byte receiver
package uart_rx_byte_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Arrow key codes the game core reacts to
    localparam logic [7:0] KEY_UP    = 8'd65;
    localparam logic [7:0] KEY_DOWN  = 8'd66;
    localparam logic [7:0] KEY_RIGHT = 8'd67;
    localparam logic [7:0] KEY_LEFT  = 8'd68;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous input
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver producing a held byte and a one-cycle strobe
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int CLKS_PER_BIT = 273,
    parameter int DATA_BITS    = 8
) (
    input  logic                 px_clk,
    input  logic                 rstn,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dataRX,
    output logic                 WR_RX,
    output logic                 frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic [2:0]           idx_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 wr_q;
    logic                 ferr_q;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk_i  (px_clk),
        .rst_ni (rstn),
        .d_i    (rx),
        .q_o    (rx_s)
    );

    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) state_q <= ST_START;
                end
                ST_START: begin
                    // Re-check the line at mid start bit to reject short glitches
                    if (cnt_q == CNT_HALF) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q   <= '0;
                        shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (idx_q == IDX_LAST) state_q <= ST_STOP;
                        else                   idx_q   <= idx_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shreg_q;
                            wr_q    <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= ST_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // A line held low must go idle before another frame can start
                    if (rx_s) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dataRX    = data_q;
    assign WR_RX     = wr_q;
    assign frame_err = ferr_q;

endmodule
